// File: rtl/spi_pkg.sv
// spi_pkg: shared state type and constants for the SPI command sequencer.
// Define SPI_CMD_SEQ_DUMMY_EN to append a 0x00 dummy byte after the address.
package spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD,
    S_LAUNCH,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam logic [7:0] DUMMY_BYTE = 8'h00;

`ifdef SPI_CMD_SEQ_DUMMY_EN
  localparam int DUMMY_N = 1;
`else
  localparam int DUMMY_N = 0;
`endif

  // Header length: opcode + address bytes + optional dummy
  function automatic int hdr_len(input int ab);
    return 1 + ab + DUMMY_N;
  endfunction

endpackage

// File: rtl/spi_hdr_mux.sv
// spi_hdr_mux: picks the header byte for a given header index.
// Index 0 is the opcode, then address MSB first, then the dummy byte
// when SPI_CMD_SEQ_DUMMY_EN is defined.
module spi_hdr_mux
  import spi_pkg::*;
#(
  parameter int ADDR_BYTES = 3,
  parameter int AW         = 24
) (
  input  logic [2:0]    i_idx,
  input  logic [7:0]    i_code,
  input  logic [AW-1:0] i_addr,
  output logic [7:0]    o_byte
);

  // Select opcode, address byte or dummy by index
  always_comb begin
    o_byte = i_code;
    for (int k = 0; k < ADDR_BYTES; k++) begin
      if (i_idx == 3'(k + 1)) begin
        o_byte = i_addr[AW-8-8*k +: 8];
      end
    end
`ifdef SPI_CMD_SEQ_DUMMY_EN
    if (i_idx == 3'(ADDR_BYTES + 1)) begin
      o_byte = DUMMY_BYTE;
    end
`endif
  end

endmodule

// File: rtl/spi_cmd_seq.sv
// spi_cmd_seq: sequences an SPI flash command through the controller FIFOs.
// Define SPI_CMD_SEQ_DUMMY_EN for a fast-read dummy byte after the address.
module spi_cmd_seq
  import spi_pkg::*;
#(
  parameter int DATA       = 8,
  parameter int ADDR_BYTES = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            cmd_op,
  input  logic [7:0]      cmd_code,
  input  logic [((ADDR_BYTES > 0) ? 8*ADDR_BYTES : 8)-1:0] cmd_addr,
  input  logic [15:0]     cmd_len,
  output logic            ready,
  output logic            done,
  output logic            err,
  input  logic [DATA-1:0] tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  output logic [DATA-1:0] rx_data,
  output logic            rx_valid,
  output logic [15:0]     len,
  output logic            op,
  output logic            work,
  input  logic            busy,
  output logic [DATA-1:0] wdata,
  output logic            wr,
  input  logic            full,
  input  logic [DATA-1:0] rdata,
  output logic            rd,
  input  logic            empty
);

  localparam int AW = (ADDR_BYTES > 0) ? 8*ADDR_BYTES : 8;
  localparam int H  = hdr_len(ADDR_BYTES);
  localparam logic [2:0]  H_LAST = 3'(H - 1);
  localparam logic [15:0] H16    = 16'(H);

  state_t          r_state;
  state_t          w_next;
  logic            r_op;
  logic [7:0]      r_code;
  logic [AW-1:0]   r_addr;
  logic [15:0]     r_clen;
  logic [15:0]     r_len;
  logic [2:0]      r_idx;
  logic [15:0]     r_cnt;
  logic [15:0]     r_rcnt;
  logic            r_bhi;
  logic            r_bdone;
  logic            r_fwd;
  logic            r_err;

  logic            w_ready;
  logic            w_go;
  logic [16:0]     w_sum;
  logic            w_ovf;
  logic [7:0]      w_hdr;

  assign w_ready = (r_state == S_IDLE) & ~busy;
  assign w_go    = start & w_ready;
  assign w_sum   = {1'b0, cmd_len} + 17'(H);
  assign w_ovf   = w_sum[16];

  spi_hdr_mux #(
    .ADDR_BYTES (ADDR_BYTES),
    .AW         (AW)
  ) u_hdr_mux (
    .i_idx  (r_idx),
    .i_code (r_code),
    .i_addr (r_addr),
    .o_byte (w_hdr)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and per-state strobes
  always_comb begin
    w_next   = r_state;
    wr       = 1'b0;
    wdata    = '0;
    tx_ready = 1'b0;
    work     = 1'b0;
    rd       = 1'b0;
    done     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_go && !w_ovf) w_next = S_HDR;
      end
      S_HDR: begin
        wdata = w_hdr;
        wr    = ~full;
        if (!full && r_idx == H_LAST) begin
          if (r_op == OP_WRITE && r_clen != 16'd0)
            w_next = S_PAYLOAD;
          else
            w_next = S_LAUNCH;
        end
      end
      S_PAYLOAD: begin
        tx_ready = ~full;
        wdata    = tx_data;
        wr       = tx_valid & ~full;
        if (tx_valid && !full && r_cnt == r_clen - 16'd1)
          w_next = S_LAUNCH;
      end
      S_LAUNCH: begin
        work   = 1'b1;
        w_next = S_RUN;
      end
      S_RUN: begin
        rd = ~empty & (r_rcnt < r_len);
        if (r_bdone && r_rcnt == r_len) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Command capture, counters, busy tracking and read forwarding
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op    <= 1'b0;
      r_code  <= '0;
      r_addr  <= '0;
      r_clen  <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_rcnt  <= '0;
      r_bhi   <= 1'b0;
      r_bdone <= 1'b0;
      r_fwd   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_go & w_ovf;
      r_fwd <= rd & (r_op == OP_READ) & (r_rcnt >= H16);
      if (w_go && !w_ovf) begin
        r_op    <= cmd_op;
        r_code  <= cmd_code;
        r_addr  <= cmd_addr;
        r_clen  <= cmd_len;
        r_len   <= w_sum[15:0];
        r_idx   <= '0;
        r_cnt   <= '0;
        r_rcnt  <= '0;
        r_bhi   <= 1'b0;
        r_bdone <= 1'b0;
      end
      if (r_state == S_HDR && wr) r_idx <= r_idx + 3'd1;
      if (r_state == S_PAYLOAD && wr) r_cnt <= r_cnt + 16'd1;
      if (rd) r_rcnt <= r_rcnt + 16'd1;
      if (r_state == S_RUN) begin
        r_bhi   <= r_bhi | busy;
        r_bdone <= r_bdone | (r_bhi & ~busy);
      end
    end
  end

  assign ready    = w_ready;
  assign err      = r_err;
  assign len      = r_len;
  assign op       = r_op;
  assign rx_valid = r_fwd;
  assign rx_data  = r_fwd ? rdata : '0;

endmodule

// File: tb/tb_spi_cmd_seq.sv
// tb_spi_cmd_seq: directed bench for spi_cmd_seq with FIFO and
// controller models; build with SPI_CMD_SEQ_DUMMY_EN for the dummy case.
module tb_spi_cmd_seq;

`ifdef SPI_CMD_SEQ_DUMMY_EN
  localparam int H = 5;
`else
  localparam int H = 4;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cmd_op;
  logic [7:0]  cmd_code;
  logic [23:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        ready, done, err;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] len;
  logic        op, work, busy;
  logic [7:0]  wdata;
  logic        wr, full;
  logic [7:0]  rdata;
  logic        rd, empty;

  always #5 clk = ~clk;

  spi_cmd_seq #(.DATA(8), .ADDR_BYTES(3)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd_op(cmd_op),
    .cmd_code(cmd_code), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .ready(ready), .done(done), .err(err),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .len(len), .op(op), .work(work), .busy(busy),
    .wdata(wdata), .wr(wr), .full(full),
    .rdata(rdata), .rd(rd), .empty(empty)
  );

  // Controller + input FIFO model: on work, push len bytes 0x50+k
  logic [7:0] inmem [256];
  logic [7:0] wp, rp;
  int c_rem, c_k, c_tail;
  assign empty = (wp == rp);

  always @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0; wp <= '0; rp <= '0; rdata <= '0;
      c_rem <= 0; c_k <= 0; c_tail <= 0;
    end else begin
      if (work) begin
        busy <= 1'b1; c_rem <= int'(len); c_k <= 0; c_tail <= 3;
      end else if (busy) begin
        if (c_rem != 0) begin
          inmem[wp] <= 8'h50 + 8'(c_k);
          wp <= wp + 8'd1;
          c_k <= c_k + 1;
          c_rem <= c_rem - 1;
        end else if (c_tail != 0) begin
          c_tail <= c_tail - 1;
        end else begin
          busy <= 1'b0;
        end
      end
      if (rd) begin
        rdata <= inmem[rp];
        rp <= rp + 8'd1;
      end
    end
  end

  // Write-payload source
  logic [7:0] txbuf [16];
  int tx_n = 0;
  int tx_i = 0;
  assign tx_valid = (tx_i < tx_n);
  assign tx_data  = txbuf[tx_i[3:0]];
  always @(posedge clk) if (tx_valid && tx_ready) tx_i <= tx_i + 1;

  // Output capture
  logic [7:0] outq [$];
  logic [7:0] rxq [$];
  int wr_cnt = 0, wrfull_cnt = 0, work_cnt = 0, done_cnt = 0, err_cnt = 0;
  logic [15:0] cap_len = '0;
  logic        cap_op = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      if (wr) begin
        wr_cnt <= wr_cnt + 1;
        if (full) wrfull_cnt <= wrfull_cnt + 1;
        else outq.push_back(wdata);
      end
      if (rx_valid) rxq.push_back(rx_data);
      if (work) begin
        work_cnt <= work_cnt + 1;
        cap_len <= len;
        cap_op <= op;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (err) err_cnt <= err_cnt + 1;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic go(input logic o, input logic [7:0] c,
                    input logic [23:0] a, input logic [15:0] l);
    @(negedge clk);
    start = 1'b1; cmd_op = o; cmd_code = c; cmd_addr = a; cmd_len = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int n = 0;
    while (done_cnt == base && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done_cnt - base, 1);
  endtask

  task automatic check_hdr(input int b, input logic [7:0] c,
                           input logic [23:0] a);
    chk("hdr_code", outq[b], c);
    chk("hdr_a2", outq[b+1], a[23:16]);
    chk("hdr_a1", outq[b+2], a[15:8]);
    chk("hdr_a0", outq[b+3], a[7:0]);
`ifdef SPI_CMD_SEQ_DUMMY_EN
    chk("hdr_dummy", outq[b+4], 0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bo, br, bw, bd, bwr, be, n;
    rst = 1'b1; start = 1'b0; cmd_op = 1'b0; cmd_code = '0;
    cmd_addr = '0; cmd_len = '0; full = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_ctrl", {wr, rd, work, op, done, err, tx_ready, rx_valid}, 0);
    chk("rst_len", len, 0);
    chk("rst_data", {wdata, rx_data}, 0);
    rst = 1'b0;

    // Read 0x03 @ 0x001900, 4 bytes
    bo = outq.size(); br = rxq.size(); bw = work_cnt;
    bd = done_cnt; bwr = wr_cnt;
    go(1'b0, 8'h03, 24'h001900, 16'd4);
    wait_done(bd);
    chk("rd_wr_count", wr_cnt - bwr, H);
    check_hdr(bo, 8'h03, 24'h001900);
    chk("rd_work", work_cnt - bw, 1);
    chk("rd_len", cap_len, H + 4);
    chk("rd_op", cap_op, 0);
    chk("rd_rx_count", rxq.size() - br, 4);
    for (int i = 0; i < 4; i++) chk("rd_rx", rxq[br+i], 8'h50 + H + i);
    chk("rd_ready", ready, 1);
    repeat (3) @(negedge clk);
    chk("rd_done_once", done_cnt - bd, 1);
    chk("rd_len_hold", len, H + 4);

    // Write 0x02 @ 0x000100, AA BB CC; a stray start during header
    txbuf[tx_n] = 8'hAA; txbuf[tx_n+1] = 8'hBB; txbuf[tx_n+2] = 8'hCC;
    @(negedge clk);
    tx_n = tx_n + 3;
    bo = outq.size(); br = rxq.size(); bw = work_cnt;
    bd = done_cnt; bwr = wr_cnt;
    go(1'b1, 8'h02, 24'h000100, 16'd3);
    start = 1'b1; cmd_op = 1'b0; cmd_code = 8'hEE; cmd_len = 16'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(bd);
    chk("wr_wr_count", wr_cnt - bwr, H + 3);
    check_hdr(bo, 8'h02, 24'h000100);
    chk("wr_pay0", outq[bo+H], 8'hAA);
    chk("wr_pay1", outq[bo+H+1], 8'hBB);
    chk("wr_pay2", outq[bo+H+2], 8'hCC);
    chk("wr_len", cap_len, H + 3);
    chk("wr_op", cap_op, 1);
    chk("wr_work", work_cnt - bw, 1);
    chk("wr_tx_used", tx_i, tx_n);
    repeat (3) @(negedge clk);
    chk("wr_rx_none", rxq.size() - br, 0);
    chk("wr_done_once", done_cnt - bd, 1);

    // Full held for 5 cycles mid-header
    bo = outq.size(); br = rxq.size(); bd = done_cnt; bwr = wr_cnt;
    be = wrfull_cnt;
    go(1'b0, 8'h9F, 24'h123456, 16'd1);
    @(negedge clk);
    full = 1'b1;
    repeat (2) @(negedge clk);
    chk("stall_wr_low", wr, 0);
    repeat (3) @(negedge clk);
    full = 1'b0;
    wait_done(bd);
    chk("stall_wr_count", wr_cnt - bwr, H);
    chk("stall_wr_full", wrfull_cnt - be, 0);
    check_hdr(bo, 8'h9F, 24'h123456);
    chk("stall_rx_count", rxq.size() - br, 1);
    chk("stall_rx", rxq[br], 8'h50 + H);

    // Length overflow is rejected
    bw = work_cnt; bwr = wr_cnt; be = err_cnt;
    go(1'b0, 8'h03, 24'h000000, 16'd65534);
    chk("err_pulse", err, 1);
    chk("err_ready", ready, 1);
    @(negedge clk);
    chk("err_low", err, 0);
    repeat (5) @(negedge clk);
    chk("err_no_wr", wr_cnt - bwr, 0);
    chk("err_no_work", work_cnt - bw, 0);
    chk("err_count", err_cnt - be, 1);
    chk("err_len_hold", len, H + 1);

    // Largest legal length is accepted, then reset out of the header
    go(1'b0, 8'h03, 24'h000000, 16'(65535 - H));
    chk("max_err", err, 0);
    chk("max_len", len, 16'hFFFF);
    chk("max_ready", ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("max_rst_ready", ready, 1);

    // Reset while in RUN, then a normal read
    go(1'b0, 8'h03, 24'h0A0B0C, 16'd4);
    n = 0;
    while (rd !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach_run", rd, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_ctrl", {wr, rd, work, op, done, err, tx_ready, rx_valid}, 0);
    chk("mid_rst_len", len, 0);
    chk("mid_rst_data", {wdata, rx_data}, 0);
    bo = outq.size(); br = rxq.size(); bd = done_cnt;
    go(1'b0, 8'h03, 24'h0A0B0C, 16'd2);
    wait_done(bd);
    check_hdr(bo, 8'h03, 24'h0A0B0C);
    chk("post_len", cap_len, H + 2);
    chk("post_rx_count", rxq.size() - br, 2);
    chk("post_rx0", rxq[br], 8'h50 + H);
    chk("post_rx1", rxq[br+1], 8'h51 + H);

`ifdef SPI_CMD_SEQ_DUMMY_EN
    // Fast read 0x0B @ 0xA2A1A0 with dummy byte, 2 bytes
    bo = outq.size(); br = rxq.size(); bd = done_cnt; bwr = wr_cnt;
    go(1'b0, 8'h0B, 24'hA2A1A0, 16'd2);
    wait_done(bd);
    chk("dm_wr_count", wr_cnt - bwr, 5);
    check_hdr(bo, 8'h0B, 24'hA2A1A0);
    chk("dm_len", cap_len, 7);
    chk("dm_rx_count", rxq.size() - br, 2);
    chk("dm_rx0", rxq[br], 8'h55);
    chk("dm_rx1", rxq[br+1], 8'h56);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
